// File: rtl/swb_pkg.sv
// ----------------------------------------------------------------------------
// swb_pkg
// Shared definitions for the posted-store write buffer (store_write_buffer).
//   SWB_DEPTH  default number of buffered stores (power of two, >= 2)
//   SWB_AW     store address width
//   SWB_DW     store data width
//   SWB_PTR_W  pointer width for the default depth
//   swb_state_e  drain FSM states
//   swb_entry_t  one buffered store {addr, data}
// ----------------------------------------------------------------------------
package swb_pkg;

  localparam int SWB_DEPTH = 4;
  localparam int SWB_AW    = 32;
  localparam int SWB_DW    = 32;
  localparam int SWB_PTR_W = $clog2(SWB_DEPTH);

  typedef enum logic {
    SWB_IDLE = 1'b0,
    SWB_REQ  = 1'b1
  } swb_state_e;

  typedef struct packed {
    logic [SWB_AW-1:0] addr;
    logic [SWB_DW-1:0] data;
  } swb_entry_t;

endpackage

// File: rtl/swb_fifo.sv
// ----------------------------------------------------------------------------
// swb_fifo
// Circular storage for buffered stores, with read/write pointers and occupancy.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   push, push_addr/data  write a new entry at the tail (ignored when full)
//   pop                   retire the head entry (ignored when empty)
//   head_addr/head_data   oldest entry
//   count, full, empty    occupancy
//   rd_ptr                head index, used by the forwarding lookup
//   entry_addr/entry_data raw storage, used by the forwarding lookup
// ----------------------------------------------------------------------------
module swb_fifo
  import swb_pkg::*;
#(
  parameter int DEPTH = SWB_DEPTH,
  parameter int AW    = SWB_AW,
  parameter int DW    = SWB_DW,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [AW-1:0]    push_addr,
  input  logic [DW-1:0]    push_data,
  input  logic             pop,
  output logic [AW-1:0]    head_addr,
  output logic [DW-1:0]    head_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic [PTR_W-1:0] rd_ptr,
  output logic [AW-1:0]    entry_addr [DEPTH],
  output logic [DW-1:0]    entry_data [DEPTH]
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [AW-1:0]    addr_q [DEPTH];
  logic [AW-1:0]    addr_d [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [DW-1:0]    data_d [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full       = (count_q == CNT_W'(DEPTH));
  assign empty      = (count_q == '0);
  assign count      = count_q;
  assign rd_ptr     = rd_ptr_q;
  assign head_addr  = addr_q[rd_ptr_q];
  assign head_data  = data_q[rd_ptr_q];
  assign entry_addr = addr_q;
  assign entry_data = data_q;

  // Pointer and occupancy update. Pointers are exactly PTR_W bits wide, so
  // DEPTH being a power of two makes the wrap from DEPTH-1 to 0 implicit.
  // The full/empty guards live here so the count can never overflow or
  // underflow whatever the caller asserts.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    addr_d   = addr_q;
    data_d   = data_q;
    do_push  = push && !full;
    do_pop   = pop && !empty;
    if (do_push) begin
      addr_d[wr_ptr_q] = push_addr;
      data_d[wr_ptr_q] = push_data;
      wr_ptr_d         = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // State registers. Storage is cleared too so the head outputs read zero
  // straight out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
    end
  end

endmodule

// File: rtl/store_write_buffer.sv
// ----------------------------------------------------------------------------
// store_write_buffer
// Posted-store buffer between the core store port and data memory. Stores are
// absorbed in one cycle and drained in issue order over a req/ack handshake;
// the core is stalled only while the buffer is full.
// Configuration macro: STORE_FWD_EN enables store-to-load forwarding
// (ld_hit/ld_data); without it those outputs are constant zero.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   memwrite, dataadr, writedata    core store port
//   stall                           store not accepted this cycle (full)
//   mem_req, mem_addr, mem_wdata    drain request carrying the head entry
//   mem_ack                         memory accepted the head entry
//   ld_addr, ld_hit, ld_data        forwarding lookup
// ----------------------------------------------------------------------------
module store_write_buffer
  import swb_pkg::*;
#(
  parameter int DEPTH = SWB_DEPTH,
  parameter int AW    = SWB_AW,
  parameter int DW    = SWB_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          memwrite,
  input  logic [AW-1:0] dataadr,
  input  logic [DW-1:0] writedata,
  output logic          stall,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [AW-1:0] ld_addr,
  output logic          ld_hit,
  output logic [DW-1:0] ld_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  swb_state_e       state_q, state_d;
  logic             pop;
  logic [AW-1:0]    head_addr;
  logic [DW-1:0]    head_data;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic [PTR_W-1:0] rd_ptr;
  logic [AW-1:0]    entry_addr [DEPTH];
  logic [DW-1:0]    entry_data [DEPTH];

  swb_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (memwrite),
    .push_addr  (dataadr),
    .push_data  (writedata),
    .pop        (pop),
    .head_addr  (head_addr),
    .head_data  (head_data),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .rd_ptr     (rd_ptr),
    .entry_addr (entry_addr),
    .entry_data (entry_data)
  );

  // A full buffer refuses the store even if the head drains this very cycle;
  // the held store goes in on the following cycle.
  assign stall = memwrite && full;

  // The memory side only sees a valid head while a request is outstanding.
  assign mem_req   = (state_q == SWB_REQ);
  assign mem_addr  = mem_req ? head_addr : '0;
  assign mem_wdata = mem_req ? head_data : '0;
  assign pop       = mem_req && mem_ack;

  // Drain FSM: every acknowledged transfer returns to IDLE, which leaves one
  // bubble cycle between consecutive drains.
  always_comb begin
    state_d = state_q;
    case (state_q)
      SWB_IDLE: if (!empty) state_d = SWB_REQ;
      SWB_REQ:  if (mem_ack) state_d = SWB_IDLE;
      default:  state_d = SWB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SWB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef STORE_FWD_EN
  logic [PTR_W-1:0] idx;

  // Walk the valid entries from oldest to youngest; a later match overrides
  // an earlier one, so ld_data ends up holding the youngest matching store.
  // Only registered entries are searched, so a same-cycle push never hits.
  always_comb begin
    ld_hit  = 1'b0;
    ld_data = '0;
    idx     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PTR_W'(i);
      if ((CNT_W'(i) < count) && (entry_addr[idx] == ld_addr)) begin
        ld_hit  = 1'b1;
        ld_data = entry_data[idx];
      end
    end
  end
`else
  logic unused_fwd;

  // Forwarding is compiled out; the lookup inputs are folded into a dummy
  // signal so the interface stays identical in both builds.
  always_comb begin
    unused_fwd = ^ld_addr ^ ^rd_ptr ^ ^count;
    for (int i = 0; i < DEPTH; i++) begin
      unused_fwd = unused_fwd ^ ^entry_addr[i] ^ ^entry_data[i];
    end
  end

  assign ld_hit  = 1'b0;
  assign ld_data = '0;
`endif

endmodule

// File: tb/tb_store_write_buffer.sv
// ----------------------------------------------------------------------------
// tb_store_write_buffer
// Self-checking bench for store_write_buffer: a directed vector table, hand
// sequences for fill/wrap/push+pop/reset/forwarding, and randomized traffic
// checked against a queue-based model of the buffer contents.
// Works with and without STORE_FWD_EN defined.
// ----------------------------------------------------------------------------
module tb_store_write_buffer;
  import swb_pkg::*;

  localparam int DEPTH = SWB_DEPTH;
  localparam int AW    = SWB_AW;
  localparam int DW    = SWB_DW;
`ifdef STORE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          memwrite;
  logic [AW-1:0] dataadr;
  logic [DW-1:0] writedata;
  logic          stall;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [AW-1:0] ld_addr;
  logic          ld_hit;
  logic [DW-1:0] ld_data;

  int errors = 0;
  int checks = 0;

  swb_entry_t    model_q[$];
  logic [AW-1:0] drained[$];

  typedef struct {
    logic          mw;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          ack;
    logic [AW-1:0] la;
    logic          exp_stall;
    logic          exp_req;
    logic [AW-1:0] exp_maddr;
    logic [DW-1:0] exp_mwdata;
    logic          exp_hit_fwd;
    logic [DW-1:0] exp_ldata_fwd;
  } vec_t;

  vec_t tbl[9];

  always #5 clk = ~clk;

  store_write_buffer dut (
    .clk       (clk),
    .reset     (reset),
    .memwrite  (memwrite),
    .dataadr   (dataadr),
    .writedata (writedata),
    .stall     (stall),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .ld_addr   (ld_addr),
    .ld_hit    (ld_hit),
    .ld_data   (ld_data)
  );

  // Single comparison with failure reporting.
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic reportTimeout(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: wait bound expired", name);
  endtask

  // Drive the inputs for the coming edge and let combinational outputs settle.
  task automatic applyStimulus(input logic mw, input logic [AW-1:0] a,
                               input logic [DW-1:0] d, input logic ack,
                               input logic [AW-1:0] la);
    memwrite  = mw;
    dataadr   = a;
    writedata = d;
    mem_ack   = ack;
    ld_addr   = la;
    #1;
  endtask

  // Compare outputs against the buffer model: stall only when the model holds
  // DEPTH stores, forwarding returns the youngest matching store, and a drain
  // request always presents the oldest store.
  task automatic modelCheck();
    logic          exp_stall;
    logic          exp_hit;
    logic [DW-1:0] exp_ld;
    exp_stall = memwrite && (model_q.size() == DEPTH);
    checkOutput("model_stall", stall, exp_stall);
    exp_hit = 1'b0;
    exp_ld  = '0;
    if (FWD) begin
      foreach (model_q[i]) begin
        if (model_q[i].addr == ld_addr) begin
          exp_hit = 1'b1;
          exp_ld  = model_q[i].data;
        end
      end
    end
    checkOutput("model_ld_hit", ld_hit, exp_hit);
    checkOutput("model_ld_data", ld_data, exp_ld);
    if (mem_req) begin
      if (model_q.size() == 0) begin
        checkOutput("model_req_while_empty", mem_req, 1'b0);
      end else begin
        checkOutput("model_mem_addr", mem_addr, model_q[0].addr);
        checkOutput("model_mem_wdata", mem_wdata, model_q[0].data);
      end
    end
  endtask

  // Advance the model with what happens on this edge, then take the edge.
  task automatic clockEdge();
    swb_entry_t e;
    logic       accept;
    if (reset) begin
      model_q.delete();
    end else begin
      accept = memwrite && (model_q.size() < DEPTH);
      if (mem_req && mem_ack && model_q.size() > 0) begin
        drained.push_back(mem_addr);
        void'(model_q.pop_front());
      end
      if (accept) begin
        e.addr = dataadr;
        e.data = writedata;
        model_q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cycle(input logic mw, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic ack, input logic [AW-1:0] la);
    applyStimulus(mw, a, d, ack, la);
    modelCheck();
    clockEdge();
  endtask

  task automatic doReset();
    reset = 1'b1;
    applyStimulus(1'b0, '0, '0, 1'b0, '0);
    clockEdge();
    reset = 1'b0;
    drained.delete();
  endtask

  task automatic drainAll(input string name);
    int g = 0;
    while ((model_q.size() > 0 || mem_req) && g < 100) begin
      cycle(1'b0, '0, '0, 1'b1, '0);
      g++;
    end
    if (g >= 100) reportTimeout(name);
  endtask

  task automatic checkDrained(input string name, input logic [AW-1:0] base, input int n);
    checkOutput({name, "_count"}, drained.size(), n);
    for (int i = 0; i < n && i < drained.size(); i++) begin
      checkOutput($sformatf("%s_order%0d", name, i), drained[i], base + AW'(4 * i));
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int k;
    int guard;

    // Single-store vectors starting from an empty buffer.
    tbl[0] = '{1'b1, 32'd20, 32'd0, 1'b0, 32'd20, 1'b0, 1'b0, 32'd0,  32'd0, 1'b0, 32'd0};
    tbl[1] = '{1'b0, 32'd0,  32'd0, 1'b1, 32'd20, 1'b0, 1'b0, 32'd0,  32'd0, 1'b1, 32'd0};
    tbl[2] = '{1'b0, 32'd0,  32'd0, 1'b0, 32'd20, 1'b0, 1'b1, 32'd20, 32'd0, 1'b1, 32'd0};
    tbl[3] = '{1'b0, 32'd0,  32'd0, 1'b0, 32'd24, 1'b0, 1'b1, 32'd20, 32'd0, 1'b0, 32'd0};
    tbl[4] = '{1'b0, 32'd0,  32'd0, 1'b0, 32'd24, 1'b0, 1'b1, 32'd20, 32'd0, 1'b0, 32'd0};
    tbl[5] = '{1'b0, 32'd0,  32'd0, 1'b1, 32'd20, 1'b0, 1'b1, 32'd20, 32'd0, 1'b1, 32'd0};
    tbl[6] = '{1'b0, 32'd0,  32'd0, 1'b0, 32'd20, 1'b0, 1'b0, 32'd0,  32'd0, 1'b0, 32'd0};
    tbl[7] = '{1'b0, 32'd0,  32'd0, 1'b1, 32'd20, 1'b0, 1'b0, 32'd0,  32'd0, 1'b0, 32'd0};
    tbl[8] = '{1'b0, 32'd0,  32'd0, 1'b0, 32'd20, 1'b0, 1'b0, 32'd0,  32'd0, 1'b0, 32'd0};

    reset = 1'b1;
    applyStimulus(1'b0, '0, '0, 1'b0, '0);
    repeat (2) @(posedge clk);
    #1;
    model_q.delete();
    checkOutput("reset_mem_req", mem_req, 1'b0);
    checkOutput("reset_mem_addr", mem_addr, '0);
    checkOutput("reset_mem_wdata", mem_wdata, '0);
    checkOutput("reset_stall", stall, 1'b0);
    checkOutput("reset_ld_hit", ld_hit, 1'b0);
    reset = 1'b0;

    // Directed single store: latency, hold-while-unacked, ack ignored while idle.
    for (int i = 0; i < 9; i++) begin
      applyStimulus(tbl[i].mw, tbl[i].a, tbl[i].d, tbl[i].ack, tbl[i].la);
      modelCheck();
      checkOutput($sformatf("vec%0d_stall", i), stall, tbl[i].exp_stall);
      checkOutput($sformatf("vec%0d_req", i), mem_req, tbl[i].exp_req);
      if (tbl[i].exp_req) begin
        checkOutput($sformatf("vec%0d_addr", i), mem_addr, tbl[i].exp_maddr);
        checkOutput($sformatf("vec%0d_wdata", i), mem_wdata, tbl[i].exp_mwdata);
      end
      checkOutput($sformatf("vec%0d_ld_hit", i), ld_hit, tbl[i].exp_hit_fwd & FWD);
      checkOutput($sformatf("vec%0d_ld_data", i), ld_data, FWD ? tbl[i].exp_ldata_fwd : '0);
      clockEdge();
    end
    checkDrained("single", 32'd20, 1);

    // Fill: fifth store stalls, stays stalled during the ack cycle, then enters.
    doReset();
    for (int i = 0; i < 4; i++) cycle(1'b1, 32'd80 + AW'(4 * i), DW'(i), 1'b0, '0);
    applyStimulus(1'b1, 32'd96, 32'd4, 1'b0, '0);
    checkOutput("fill_stall_5th", stall, 1'b1);
    modelCheck();
    clockEdge();
    applyStimulus(1'b1, 32'd96, 32'd4, 1'b1, '0);
    checkOutput("fill_stall_on_ack", stall, 1'b1);
    modelCheck();
    clockEdge();
    applyStimulus(1'b1, 32'd96, 32'd4, 1'b0, '0);
    checkOutput("fill_accept_after_ack", stall, 1'b0);
    modelCheck();
    clockEdge();
    drainAll("fill_drain");
    checkDrained("fill", 32'd80, 5);

    // Wrap: ten stores with ack tied high; stalled stores are held by the core.
    doReset();
    k = 0;
    guard = 0;
    while (k < 10 && guard < 200) begin
      applyStimulus(1'b1, 32'h100 + AW'(4 * k), DW'(k), 1'b1, '0);
      modelCheck();
      if (!stall) k++;
      clockEdge();
      guard++;
    end
    if (guard >= 200) reportTimeout("wrap_issue");
    drainAll("wrap_drain");
    checkDrained("wrap", 32'h100, 10);

    // Push and pop on the same edge with two entries buffered.
    doReset();
    cycle(1'b1, 32'd40, 32'd1, 1'b0, '0);
    cycle(1'b1, 32'd44, 32'd2, 1'b0, '0);
    applyStimulus(1'b1, 32'd48, 32'd3, 1'b1, '0);
    checkOutput("pp_req", mem_req, 1'b1);
    checkOutput("pp_head", mem_addr, 32'd40);
    modelCheck();
    clockEdge();
    applyStimulus(1'b0, '0, '0, 1'b0, '0);
    checkOutput("pp_bubble", mem_req, 1'b0);
    clockEdge();
    applyStimulus(1'b0, '0, '0, 1'b0, '0);
    checkOutput("pp_req_again", mem_req, 1'b1);
    checkOutput("pp_head_advanced", mem_addr, 32'd44);
    modelCheck();
    clockEdge();
    cycle(1'b1, 32'd52, 32'd4, 1'b0, '0);
    cycle(1'b1, 32'd56, 32'd5, 1'b0, '0);
    applyStimulus(1'b1, 32'd60, 32'd6, 1'b0, '0);
    checkOutput("pp_full_after_two", stall, 1'b1);
    modelCheck();
    clockEdge();
    drainAll("pp_drain");
    checkDrained("pp", 32'd40, 5);

    // Reset while a drain is outstanding discards everything.
    doReset();
    cycle(1'b1, 32'd300, 32'd7, 1'b0, '0);
    cycle(1'b1, 32'd304, 32'd8, 1'b0, '0);
    cycle(1'b1, 32'd308, 32'd9, 1'b0, '0);
    applyStimulus(1'b0, '0, '0, 1'b0, '0);
    checkOutput("rst_pre_req", mem_req, 1'b1);
    reset = 1'b1;
    clockEdge();
    reset = 1'b0;
    applyStimulus(1'b0, '0, '0, 1'b1, 32'd300);
    checkOutput("rst_req_drop", mem_req, 1'b0);
    checkOutput("rst_addr_zero", mem_addr, '0);
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, '0, '0, 1'b1, 32'd300);
      checkOutput($sformatf("rst_no_write%0d", i), mem_req, 1'b0);
    end
    checkOutput("rst_drained", drained.size(), 0);

    // Forwarding: youngest match wins, same-cycle push excluded.
    doReset();
    cycle(1'b1, 32'd20, 32'h11, 1'b0, '0);
    applyStimulus(1'b1, 32'd20, 32'h22, 1'b0, 32'd20);
    checkOutput("fwd_one_hit", ld_hit, FWD);
    checkOutput("fwd_one_data", ld_data, FWD ? 32'h11 : 32'h0);
    modelCheck();
    clockEdge();
    applyStimulus(1'b1, 32'd24, 32'h33, 1'b0, 32'd24);
    checkOutput("fwd_same_cycle_push", ld_hit, 1'b0);
    modelCheck();
    clockEdge();
    applyStimulus(1'b0, '0, '0, 1'b0, 32'd20);
    checkOutput("fwd_youngest_hit", ld_hit, FWD);
    checkOutput("fwd_youngest_data", ld_data, FWD ? 32'h22 : 32'h0);
    modelCheck();
    clockEdge();
    applyStimulus(1'b0, '0, '0, 1'b0, 32'd28);
    checkOutput("fwd_miss", ld_hit, 1'b0);
    modelCheck();
    clockEdge();
    drainAll("fwd_drain");

    // Random traffic against the model.
    doReset();
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), AW'(4 * $urandom_range(0, 7)), DW'($urandom),
            1'($urandom_range(0, 1)), AW'(4 * $urandom_range(0, 7)));
    end
    drainAll("rand_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
